// File: rtl/risc5_mem_pkg.sv
// risc5_mem_pkg
// Shared constants and helpers for the RISC5 SRAM arbiter slice.
//   SRAM_AW          : SRAM word-address width (256K words)
//   FB_BASE_DEFAULT  : word address of the first framebuffer word
//   FB_WORDS_DEFAULT : words fetched per frame (1024x768 at 1 bpp)
//   lane_be()        : CPU byte-lane enables from ben and adr[1:0]
package risc5_mem_pkg;

  localparam int SRAM_AW = 18;
  localparam logic [SRAM_AW-1:0] FB_BASE_DEFAULT = 18'h37FC0;
  localparam int FB_WORDS_DEFAULT = 24576;

  // Word access enables all four lanes; a byte access enables the one
  // lane selected by the low address bits (00 -> 0001, 11 -> 1000).
  function automatic logic [3:0] lane_be(input logic ben, input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b1111;
    if (ben) begin
      be = 4'b0001 << lane;
    end
    return be;
  endfunction

endpackage

// File: rtl/risc5_vid_fifo.sv
// risc5_vid_fifo
// Synchronous show-ahead FIFO between the video prefetch slots and scanout.
//   clk, rst : clock and synchronous active-high reset
//   flush    : empties the FIFO (same effect as reset on pointers/count)
//   push/din : write a word; ignored when full
//   pop      : advance the head; ignored when empty
//   dout     : head word, valid whenever empty is low
//   count    : current occupancy
//   empty    : occupancy is zero
// DEPTH must be a power of two and at least 2.
module risc5_vid_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push & (count_q != (AW+1)'(DEPTH)) & ~flush;
  assign do_pop  = pop & (count_q != '0) & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      // Simultaneous push and pop leave occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset; one write port per entry keeps the array tiny
  // and lets the head be read combinationally for show-ahead.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (do_push && (wr_ptr_q == AW'(gi))) begin
        mem_q[gi] <= din;
      end
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/risc5_sram_arbiter.sv
// risc5_sram_arbiter
// Memory-side responder for the RISC5 CPU bus driving one asynchronous
// 32-bit SRAM. CPU accesses run in zero wait states; the video prefetch
// engine steals single-cycle slots (CPU stalled via stallX) to keep the
// scanout FIFO topped up.
//   clk, rst                : clock, synchronous active-high reset
//   adr, rd, wr, ben, outbus: CPU bus request
//   inbus, codebus          : load / instruction data to the CPU
//   stallX                  : CPU stall, high during a video slot
//   sram_*                  : asynchronous SRAM interface
//   vid_start               : frame-start pulse (highest priority)
//   vid_rd_en, vid_data     : show-ahead pop interface to scanout
//   vid_empty, vid_underrun : FIFO empty, sticky underrun flag
module risc5_sram_arbiter
  import risc5_mem_pkg::*;
#(
  parameter logic [SRAM_AW-1:0] FB_BASE = FB_BASE_DEFAULT,
  parameter int FB_WORDS   = FB_WORDS_DEFAULT,
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_LOW   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [23:0]        adr,
  input  logic               rd,
  input  logic               wr,
  input  logic               ben,
  input  logic [31:0]        outbus,
  output logic [31:0]        inbus,
  output logic [31:0]        codebus,
  output logic               stallX,
  output logic [SRAM_AW-1:0] sram_adr,
  input  logic [31:0]        sram_din,
  output logic [31:0]        sram_dout,
  output logic               sram_we,
  output logic [3:0]         sram_be,
  input  logic               vid_start,
  input  logic               vid_rd_en,
  output logic [31:0]        vid_data,
  output logic               vid_empty,
  output logic               vid_underrun
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int RW = SRAM_AW + 1;

  logic               slot_q, slot_d;
  logic               vid_active_q, vid_active_d;
  logic               underrun_q, underrun_d;
  logic [SRAM_AW-1:0] ptr_q, ptr_d;
  logic [RW-1:0]      remaining_q, remaining_d;
  logic [CW-1:0]      fifo_count;
  logic               fifo_push, fifo_pop;
  logic               unused_bits;

  // Loads are combinational and rd is implied by the CPU cycle, so rd and
  // the address bits above the SRAM window are not decoded here.
  assign unused_bits = ^{adr[23:20], rd};

  // A slot that coincides with vid_start is discarded by the flush.
  assign fifo_push = slot_q & ~vid_start;
  assign fifo_pop  = vid_rd_en & ~vid_empty;

  // Slot grant depends only on registered state and vid_start, never on
  // rd/wr, because the CPU qualifies its strobes with stallX.
  assign slot_d = vid_active_q & (fifo_count < CW'(FIFO_LOW)) & ~slot_q & ~vid_start;

  always_comb begin
    vid_active_d = vid_active_q;
    underrun_d   = underrun_q;
    ptr_d        = ptr_q;
    remaining_d  = remaining_q;
    if (vid_start) begin
      vid_active_d = 1'b1;
      underrun_d   = 1'b0;
      ptr_d        = FB_BASE;
      remaining_d  = RW'(FB_WORDS);
    end else begin
      if (vid_rd_en && vid_empty) underrun_d = 1'b1;
      if (fifo_push) begin
        ptr_d       = ptr_q + 1'b1;   // wraps modulo 2^18
        remaining_d = remaining_q - 1'b1;
        if (remaining_q == RW'(1)) vid_active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q       <= 1'b0;
      vid_active_q <= 1'b0;
      underrun_q   <= 1'b0;
      ptr_q        <= FB_BASE;
      remaining_q  <= '0;
    end else begin
      slot_q       <= slot_d;
      vid_active_q <= vid_active_d;
      underrun_q   <= underrun_d;
      ptr_q        <= ptr_d;
      remaining_q  <= remaining_d;
    end
  end

  risc5_vid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (vid_start),
    .push  (fifo_push),
    .din   (sram_din),
    .pop   (fifo_pop),
    .dout  (vid_data),
    .count (fifo_count),
    .empty (vid_empty)
  );

  // SRAM port mux: the video slot owns the address and forces a read.
  assign sram_adr  = slot_q ? ptr_q : adr[19:2];
  assign sram_we   = slot_q ? 1'b0 : wr;
  assign sram_be   = slot_q ? 4'b1111 : lane_be(ben, adr[1:0]);
  assign sram_dout = outbus;
  assign inbus     = sram_din;
  assign codebus   = sram_din;

  assign stallX       = slot_q;
  assign vid_underrun = underrun_q;

endmodule

// File: tb/tb_risc5_sram_arbiter.sv
module tb_risc5_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] adr;
  logic        rd, wr, ben;
  logic [31:0] outbus;

  // Main instance (default frame size)
  logic [31:0] inbus, codebus, sram_din, sram_dout, vid_data;
  logic [17:0] sram_adr;
  logic        stallX, sram_we, vid_empty, vid_underrun, vid_start, vid_rd_en;
  logic [3:0]  sram_be;

  // Short-frame instance (FB_WORDS = 6)
  logic [31:0] inbus2, codebus2, sram_din2, sram_dout2, vid_data2;
  logic [17:0] sram_adr2;
  logic        stallX2, sram_we2, vid_empty2, vid_underrun2, vid_start2, vid_rd_en2;
  logic [3:0]  sram_be2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // SRAM contents model: a fixed pattern derived from the word address.
  function automatic logic [31:0] mem_word(input logic [17:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign sram_din  = mem_word(sram_adr);
  assign sram_din2 = mem_word(sram_adr2);

  risc5_sram_arbiter dut (
    .clk(clk), .rst(rst), .adr(adr), .rd(rd), .wr(wr), .ben(ben), .outbus(outbus),
    .inbus(inbus), .codebus(codebus), .stallX(stallX), .sram_adr(sram_adr),
    .sram_din(sram_din), .sram_dout(sram_dout), .sram_we(sram_we), .sram_be(sram_be),
    .vid_start(vid_start), .vid_rd_en(vid_rd_en), .vid_data(vid_data),
    .vid_empty(vid_empty), .vid_underrun(vid_underrun)
  );

  risc5_sram_arbiter #(.FB_WORDS(6)) dut2 (
    .clk(clk), .rst(rst), .adr(adr), .rd(rd), .wr(wr), .ben(ben), .outbus(outbus),
    .inbus(inbus2), .codebus(codebus2), .stallX(stallX2), .sram_adr(sram_adr2),
    .sram_din(sram_din2), .sram_dout(sram_dout2), .sram_we(sram_we2), .sram_be(sram_be2),
    .vid_start(vid_start2), .vid_rd_en(vid_rd_en2), .vid_data(vid_data2),
    .vid_empty(vid_empty2), .vid_underrun(vid_underrun2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; adr = '0; rd = 1'b0; wr = 1'b0; ben = 1'b0; outbus = '0;
    vid_start = 1'b0; vid_rd_en = 1'b0; vid_start2 = 1'b0; vid_rd_en2 = 1'b0;
    repeat (3) tick();
    sample();
    checks++;
    if (stallX !== 1'b0 || vid_empty !== 1'b1 || vid_underrun !== 1'b0) begin
      failures++;
      $display("FAIL reset: stallX=%b empty=%b underrun=%b required 0/1/0", stallX, vid_empty, vid_underrun);
    end
    checks++;
    if (stallX2 !== 1'b0 || vid_empty2 !== 1'b1 || vid_underrun2 !== 1'b0) begin
      failures++;
      $display("FAIL reset2: stallX=%b empty=%b underrun=%b required 0/1/0", stallX2, vid_empty2, vid_underrun2);
    end
    $display("reset: stallX=%b empty=%b underrun=%b", stallX, vid_empty, vid_underrun);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      adr = 24'($urandom);
      rd = 1'b1;
      sample();
      checks++;
      if (stallX !== 1'b0 || sram_we !== 1'b0 || vid_empty !== 1'b1 ||
          sram_adr !== adr[19:2] || codebus !== mem_word(adr[19:2])) begin
        failures++;
        bad++;
        $display("FAIL idle[%0d]: stallX=%b we=%b adr=%h code=%h required 0/0/%h/%h",
                 i, stallX, sram_we, sram_adr, codebus, adr[19:2], mem_word(adr[19:2]));
      end
    end
    rd = 1'b0;
    $display("idle: 100 cycles, %0d bad", bad);
  endtask

  task automatic test_store();
    logic [23:0] t_adr [4] = '{24'h000102, 24'h000102, 24'h000103, 24'h0FF100};
    logic        t_ben [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [17:0] t_wa  [4] = '{18'h00040, 18'h00040, 18'h00040, 18'h3FC40};
    logic [3:0]  t_be  [4] = '{4'b0100, 4'b1111, 4'b1000, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      tick();
      adr = t_adr[i]; ben = t_ben[i]; wr = 1'b1; outbus = 32'hABABABAB;
      sample();
      checks++;
      if (sram_adr !== t_wa[i] || sram_be !== t_be[i] || sram_we !== 1'b1 || sram_dout !== 32'hABABABAB) begin
        failures++;
        $display("FAIL store[%0d]: adr=%h be=%b we=%b dout=%h required %h/%b/1/abababab",
                 i, sram_adr, sram_be, sram_we, sram_dout, t_wa[i], t_be[i]);
      end
      $display("store[%0d]: adr=%h be=%b we=%b", i, sram_adr, sram_be, sram_we);
    end
    tick();
    wr = 1'b0; ben = 1'b0;
  endtask

  task automatic test_frame_start();
    int k;
    logic exp_stall;
    k = 0;
    tick();
    vid_start = 1'b1;
    sample();
    for (int c = 1; c <= 14; c++) begin
      tick();
      vid_start = 1'b0;
      adr = 24'h001000 + 24'(c * 4);
      sample();
      exp_stall = (c >= 2) && (c <= 8) && (c % 2 == 0);
      checks++;
      if (stallX !== exp_stall) begin
        failures++;
        $display("FAIL slot_pattern c=%0d: stallX=%b required %b", c, stallX, exp_stall);
      end else if (exp_stall) begin
        checks++;
        if (sram_adr !== 18'h37FC0 + 18'(k) || sram_we !== 1'b0 || sram_be !== 4'b1111) begin
          failures++;
          $display("FAIL slot_adr c=%0d: adr=%h we=%b be=%b required %h/0/1111",
                   c, sram_adr, sram_we, sram_be, 18'h37FC0 + 18'(k));
        end
        k++;
      end else begin
        checks++;
        if (inbus !== mem_word(adr[19:2]) || sram_adr !== adr[19:2]) begin
          failures++;
          $display("FAIL cpu_load c=%0d: inbus=%h required %h", c, inbus, mem_word(adr[19:2]));
        end
      end
      $display("frame c=%0d: stallX=%b sram_adr=%h", c, stallX, sram_adr);
    end
    checks++;
    if (vid_empty !== 1'b0 || vid_data !== mem_word(18'h37FC0)) begin
      failures++;
      $display("FAIL fifo_head: empty=%b data=%h required 0/%h", vid_empty, vid_data, mem_word(18'h37FC0));
    end
  endtask

  task automatic test_pop_stream();
    for (int p = 0; p < 64; p++) begin
      tick();
      vid_rd_en = 1'b1;
      sample();
      checks++;
      if (vid_empty !== 1'b0 || vid_data !== mem_word(18'h37FC0 + 18'(p))) begin
        failures++;
        $display("FAIL pop[%0d]: empty=%b data=%h required 0/%h", p, vid_empty, vid_data, mem_word(18'h37FC0 + 18'(p)));
      end
      $display("pop[%0d]: data=%h", p, vid_data);
      tick();
      vid_rd_en = 1'b0;
      repeat (2) tick();
    end
    sample();
    checks++;
    if (vid_underrun !== 1'b0) begin
      failures++;
      $display("FAIL stream_underrun: underrun=%b required 0", vid_underrun);
    end
  endtask

  task automatic test_short_frame();
    int nslots, npop;
    logic pop;
    nslots = 0; npop = 0;
    tick();
    vid_start2 = 1'b1;
    tick();
    vid_start2 = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i > 0) tick();
      pop = (i % 4 == 0) && !vid_empty2;
      vid_rd_en2 = pop;
      sample();
      if (stallX2) nslots++;
      if (pop) begin
        checks++;
        if (vid_data2 !== mem_word(18'h37FC0 + 18'(npop))) begin
          failures++;
          $display("FAIL short_data[%0d]: data=%h required %h", npop, vid_data2, mem_word(18'h37FC0 + 18'(npop)));
        end
        npop++;
      end
    end
    tick();
    vid_rd_en2 = 1'b0;
    sample();
    checks++;
    if (nslots != 6 || npop != 6) begin
      failures++;
      $display("FAIL short_slots: slots=%0d pops=%0d required 6/6", nslots, npop);
    end
    $display("short frame: slots=%0d pops=%0d", nslots, npop);
    checks++;
    if (stallX2 !== 1'b0 || vid_empty2 !== 1'b1 || vid_underrun2 !== 1'b0) begin
      failures++;
      $display("FAIL short_end: stallX=%b empty=%b underrun=%b required 0/1/0", stallX2, vid_empty2, vid_underrun2);
    end
    // Pop while empty: sticky underrun, FIFO stays empty.
    tick();
    vid_rd_en2 = 1'b1;
    tick();
    vid_rd_en2 = 1'b0;
    sample();
    checks++;
    if (vid_underrun2 !== 1'b1 || vid_empty2 !== 1'b1) begin
      failures++;
      $display("FAIL underrun: underrun=%b empty=%b required 1/1", vid_underrun2, vid_empty2);
    end
    $display("underrun: underrun=%b empty=%b", vid_underrun2, vid_empty2);
    // Restart clears underrun and begins again at the base address.
    tick();
    vid_start2 = 1'b1;
    tick();
    vid_start2 = 1'b0;
    sample();
    checks++;
    if (vid_underrun2 !== 1'b0 || stallX2 !== 1'b0) begin
      failures++;
      $display("FAIL restart2: underrun=%b stallX=%b required 0/0", vid_underrun2, stallX2);
    end
    tick();
    sample();
    checks++;
    if (stallX2 !== 1'b1 || sram_adr2 !== 18'h37FC0) begin
      failures++;
      $display("FAIL restart2_slot: stallX=%b adr=%h required 1/37fc0", stallX2, sram_adr2);
    end
    $display("restart2: stallX=%b adr=%h", stallX2, sram_adr2);
  endtask

  task automatic wait_slot(input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (stallX) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL %s_wait: stallX=%b required 1 within 12 cycles", name, stallX);
    end
  endtask

  task automatic test_midframe_restart();
    tick();
    vid_rd_en = 1'b1;
    tick();
    vid_rd_en = 1'b0;
    wait_slot("midframe");
    vid_start = 1'b1;
    tick();
    vid_start = 1'b0;
    sample();
    checks++;
    if (vid_empty !== 1'b1 || stallX !== 1'b0 || vid_underrun !== 1'b0) begin
      failures++;
      $display("FAIL midframe_flush: empty=%b stallX=%b underrun=%b required 1/0/0", vid_empty, stallX, vid_underrun);
    end
    tick();
    sample();
    checks++;
    if (stallX !== 1'b1 || sram_adr !== 18'h37FC0) begin
      failures++;
      $display("FAIL midframe_slot: stallX=%b adr=%h required 1/37fc0", stallX, sram_adr);
    end
    tick();
    sample();
    checks++;
    if (vid_empty !== 1'b0 || vid_data !== mem_word(18'h37FC0)) begin
      failures++;
      $display("FAIL midframe_head: empty=%b data=%h required 0/%h", vid_empty, vid_data, mem_word(18'h37FC0));
    end
    $display("midframe restart: head=%h", vid_data);
  endtask

  task automatic test_reset_midframe();
    int hi;
    tick();
    vid_rd_en = 1'b1;
    tick();
    vid_rd_en = 1'b0;
    wait_slot("rst_midframe");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sample();
    checks++;
    if (stallX !== 1'b0 || vid_empty !== 1'b1) begin
      failures++;
      $display("FAIL rst_midframe: stallX=%b empty=%b required 0/1", stallX, vid_empty);
    end
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      sample();
      if (stallX) hi++;
    end
    checks++;
    if (hi != 0) begin
      failures++;
      $display("FAIL rst_inactive: stall cycles=%0d required 0", hi);
    end
    $display("reset mid-frame: stallX=%b empty=%b", stallX, vid_empty);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle();
    test_store();
    test_frame_start();
    test_pop_stream();
    test_short_frame();
    test_midframe_restart();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/risc5_sram_arbiter.md
Name: risc5_sram_arbiter

Overview:
- Memory-side responder for the RISC5 CPU bus.
- Drives a single-port asynchronous 32-bit SRAM, 256K words.
- Serves CPU instruction fetch, load and store in zero wait states.
- Steals single-cycle SRAM slots for a video refresh prefetch engine, stalling the CPU through stallX, and feeds fetched framebuffer words to the video scanout through an internal FIFO.

Parameters:
- FB_BASE, 18'h37FC0, word address of the first framebuffer word.
- FB_WORDS, 24576, words fetched per frame (1024x768, 1 bpp).
- FIFO_DEPTH, 8, video FIFO entries; must be a power of 2.
- FIFO_LOW, 4, refill threshold; must satisfy 1 <= FIFO_LOW <= FIFO_DEPTH-1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- adr  in  24  CPU byte address
- rd  in  1  CPU load strobe
- wr  in  1  CPU store strobe
- ben  in  1  CPU byte access
- outbus  in  32  CPU store data; byte already replicated to its lane
- inbus  out  32  load data to CPU
- codebus  out  32  instruction word to CPU
- stallX  out  1  CPU stall; high during a video slot
- sram_adr  out  18  SRAM word address
- sram_din  in  32  SRAM read data, combinational
- sram_dout  out  32  SRAM write data
- sram_we  out  1  SRAM write enable
- sram_be  out  4  SRAM byte enables
- vid_start  in  1  frame-start pulse
- vid_rd_en  in  1  pop request from scanout
- vid_data  out  32  FIFO head word, show-ahead
- vid_empty  out  1  FIFO empty
- vid_underrun  out  1  sticky: pop attempted while empty

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - stallX=0, vid_empty=1, vid_underrun=0
  - FIFO count=0, vid_active=0, ptr=FB_BASE, remaining=0
- stallX is a registered flag, slot. It must never depend combinationally on rd or wr, because the CPU masks rd/wr with stallX.
- CPU cycle (slot=0):
  - sram_adr=adr[19:2]
  - inbus=codebus=sram_din
  - sram_dout=outbus
  - sram_we=wr
  - sram_be=4'b1111 when ben=0, else one-hot of adr[1:0] (00 gives 0001, 11 gives 1000)
  - Loads complete in the same cycle; no CPU wait states.
- Video slot (slot=1):
  - sram_adr=ptr, sram_we=0, sram_be=4'b1111.
  - inbus and codebus still equal sram_din; the CPU ignores them while stalled.
  - At the closing edge: push sram_din, ptr+1, remaining-1.
- Slot grant, registered: slot_next = vid_active & (count < FIFO_LOW) & ~slot & ~vid_start. Slots are never back-to-back, so the CPU gets at least every other cycle.
- Overflow is impossible: a push only occurs when count < FIFO_LOW <= FIFO_DEPTH-1.
- vid_start has priority over everything. At the edge:
  - flush the FIFO
  - ptr=FB_BASE, remaining=FB_WORDS
  - vid_active=1, vid_underrun=0
  - clear slot_next
  - If vid_start coincides with an active slot, that slot's data is discarded.
- Frame end: when remaining reaches 0 after a push, vid_active=0. No further slots until the next vid_start.
- FIFO:
  - Pop when vid_rd_en & ~vid_empty.
  - Push and pop in the same cycle leave count unchanged.
  - vid_rd_en while empty is ignored and sets vid_underrun.
- ptr wraps modulo 2^18.
- Reset mid-frame: vid_active=0, the FIFO is emptied, and stallX drops at that edge.

Decomposition:
- Package risc5_mem_pkg holds:
  - SRAM_AW=18
  - default FB_BASE and FB_WORDS
  - a function lane_be(ben, adr[1:0]) returning 4-bit enables
- Sub-module risc5_vid_fifo: synchronous show-ahead FIFO.
  - Ports: clk, rst, flush, push, din, pop, dout, count, empty.
  - Depth set by FIFO_DEPTH.

Test Plan:
- Reset, idle with vid_start never asserted -> stallX=0 for 100 cycles, vid_empty=1, sram_we=0; codebus tracks sram_din at sram_adr=adr[19:2].
- Store byte adr=24'h000102, ben=1, wr=1, outbus=32'hABABABAB -> sram_adr=18'h40, sram_be=4'b0100, sram_we=1; word store with ben=0 -> sram_be=4'b1111.
- vid_start pulse, no pops -> slots at cycles +1,+3,+5,+7 with sram_adr 37FC0..37FC3; stallX alternates 1,0; count reaches 4, then no further slots; CPU loads in slot-free cycles return sram_din.
- Pop one word every 4 cycles over 64 pops -> vid_data sequence equals SRAM contents at 37FC0 onward, vid_underrun stays 0. Then pop with FIFO empty -> vid_underrun=1, count unchanged.
- FB_WORDS=6 override -> exactly 6 slots, vid_active falls, stallX stays 0 afterwards; next vid_start restarts at 37FC0.
- vid_start on a slot cycle mid-frame -> FIFO empty next cycle, underrun cleared, next slot reads 37FC0; rst mid-frame -> stallX=0 and vid_empty=1 after that edge.
